// File: rtl/osd_reg_access.sv
// OSD register-access front end: decodes DII read/write request packets, serves the
// base registers and forwards module registers. Optional stall register: OSD_REGACCESS_STALL_EN.
package osd_dii_pkg;
  typedef struct packed {
    logic        valid;
    logic        last;
    logic [15:0] data;
  } dii_flit;
endpackage

module osd_reg_access
  import osd_dii_pkg::*;
#(
  parameter logic [15:0] MODID        = 16'h0,
  parameter logic [15:0] MODVERSION   = 16'h0,
  parameter int unsigned MAX_REG_SIZE = 16
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [9:0]              id,
  input  dii_flit                 debug_in,
  output logic                    debug_in_ready,
  output dii_flit                 debug_out,
  input  logic                    debug_out_ready,
  output logic                    reg_request,
  output logic                    reg_write,
  output logic [15:0]             reg_addr,
  output logic [1:0]              reg_size,
  output logic [MAX_REG_SIZE-1:0] reg_wdata,
  input  logic                    reg_ack,
  input  logic                    reg_err,
  input  logic [MAX_REG_SIZE-1:0] reg_rdata,
  output logic                    stall
);

  typedef enum logic [3:0] {
    IDLE, SRC, HDR, ADDR, WDATA, ACCESS, RDEST, RSRC, RHDR, RDATA, DRAIN
  } state_t;

  state_t                  state_q, state_d;
  logic [9:0]              src_q, src_d;
  logic                    write_q, write_d;
  logic [1:0]              size_q, size_d;
  logic [15:0]             addr_q, addr_d;
  logic [MAX_REG_SIZE-1:0] wdata_q, wdata_d;
  logic [MAX_REG_SIZE-1:0] rdata_q, rdata_d;
  logic [3:0]              resp_sub_q, resp_sub_d;
  logic [2:0]              cnt_q, cnt_d;
`ifdef OSD_REGACCESS_STALL_EN
  logic                    stall_q, stall_d;
`endif

  logic                    in_fire, out_fire, req_done;
  logic [2:0]              last_idx;
  logic [15:0]             acc_addr;
  logic [MAX_REG_SIZE-1:0] rd_shift;

  assign reg_request = (state_q == ACCESS);
  assign reg_write   = write_q;
  assign reg_addr    = addr_q;
  assign reg_size    = size_q;
  assign reg_wdata   = wdata_q;
`ifdef OSD_REGACCESS_STALL_EN
  assign stall = stall_q;
`else
  assign stall = 1'b0;
`endif

  always_comb begin
    state_d        = state_q;
    src_d          = src_q;
    write_d        = write_q;
    size_d         = size_q;
    addr_d         = addr_q;
    wdata_d        = wdata_q;
    rdata_d        = rdata_q;
    resp_sub_d     = resp_sub_q;
    cnt_d          = cnt_q;
`ifdef OSD_REGACCESS_STALL_EN
    stall_d        = stall_q;
`endif
    req_done       = 1'b0;
    debug_out      = '0;
    debug_in_ready = 1'b0;
    last_idx       = 3'((4'd1 << size_q) - 4'd1);
    // Read responses are sent MSB chunk first; cnt_q counts chunks already sent.
    rd_shift       = rdata_q >> {3'(last_idx - cnt_q), 4'b0000};
    acc_addr       = (state_q == ADDR) ? debug_in.data : addr_q;

    case (state_q)
      IDLE, SRC, HDR, ADDR, WDATA, DRAIN: debug_in_ready = 1'b1;
      default: ;
    endcase
    in_fire  = debug_in.valid & debug_in_ready;
    out_fire = debug_out_ready;

    case (state_q)
      IDLE: if (in_fire) state_d = debug_in.last ? IDLE : SRC;
      SRC: if (in_fire) begin
        src_d   = debug_in.data[9:0];
        state_d = debug_in.last ? IDLE : HDR;
      end
      HDR: if (in_fire) begin
        write_d = debug_in.data[12];
        size_d  = debug_in.data[11:10];
        if (debug_in.last)
          state_d = IDLE;
        else if (debug_in.data[15:14] != 2'b00 || debug_in.data[13])
          state_d = DRAIN;
        else
          state_d = ADDR;
      end
      ADDR: if (in_fire) begin
        addr_d  = debug_in.data;
        wdata_d = '0;
        cnt_d   = '0;
        if (write_q)        state_d = debug_in.last ? IDLE : WDATA;
        else if (debug_in.last) req_done = 1'b1;
        else                state_d = DRAIN;
      end
      WDATA: if (in_fire) begin
        wdata_d = (wdata_q << 16) | MAX_REG_SIZE'(debug_in.data);
        if (cnt_q == last_idx) begin
          if (debug_in.last) req_done = 1'b1;
          else               state_d  = DRAIN;
        end else if (debug_in.last) begin
          state_d = IDLE;
        end else begin
          cnt_d = 3'(cnt_q + 3'd1);
        end
      end
      ACCESS: begin
        if (reg_err) begin
          resp_sub_d = write_q ? 4'd15 : 4'd12;
          state_d    = RDEST;
        end else if (reg_ack) begin
          resp_sub_d = write_q ? 4'd14 : {2'b10, size_q};
          rdata_d    = reg_rdata;
          state_d    = RDEST;
        end
      end
      RDEST: begin
        debug_out = '{valid: 1'b1, last: 1'b0, data: {6'h0, src_q}};
        if (out_fire) state_d = RSRC;
      end
      RSRC: begin
        debug_out = '{valid: 1'b1, last: 1'b0, data: {6'h0, id}};
        if (out_fire) state_d = RHDR;
      end
      RHDR: begin
        // Subtype bit 2 is clear only for read success, the one case with data flits.
        debug_out = '{valid: 1'b1, last: resp_sub_q[2], data: {2'b00, resp_sub_q, 10'h0}};
        if (out_fire) begin
          cnt_d   = '0;
          state_d = resp_sub_q[2] ? IDLE : RDATA;
        end
      end
      RDATA: begin
        debug_out = '{valid: 1'b1, last: (cnt_q == last_idx), data: rd_shift[15:0]};
        if (out_fire) begin
          if (cnt_q == last_idx) state_d = IDLE;
          else                   cnt_d   = 3'(cnt_q + 3'd1);
        end
      end
      DRAIN: if (in_fire && debug_in.last) state_d = IDLE;
      default: state_d = IDLE;
    endcase

    if (req_done) begin
      state_d    = RDEST;
      resp_sub_d = write_q ? 4'd15 : 4'd12;
      if (acc_addr >= 16'h0200) begin
        if ((32'd16 << size_q) <= MAX_REG_SIZE) state_d = ACCESS;
      end else if (size_q == 2'd0) begin
        case (acc_addr)
          16'h0000: if (!write_q) begin
            resp_sub_d = 4'd8;
            rdata_d    = MAX_REG_SIZE'(MODID);
          end
          16'h0001: if (!write_q) begin
            resp_sub_d = 4'd8;
            rdata_d    = MAX_REG_SIZE'(MODVERSION);
          end
`ifdef OSD_REGACCESS_STALL_EN
          16'h0002: if (write_q) begin
            resp_sub_d = 4'd14;
            stall_d    = debug_in.data[0];
          end else begin
            resp_sub_d = 4'd8;
            rdata_d    = MAX_REG_SIZE'({15'h0, stall_q});
          end
`endif
          default: ;
        endcase
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= IDLE;
      src_q      <= '0;
      write_q    <= 1'b0;
      size_q     <= '0;
      addr_q     <= '0;
      wdata_q    <= '0;
      rdata_q    <= '0;
      resp_sub_q <= '0;
      cnt_q      <= '0;
`ifdef OSD_REGACCESS_STALL_EN
      stall_q    <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      src_q      <= src_d;
      write_q    <= write_d;
      size_q     <= size_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      rdata_q    <= rdata_d;
      resp_sub_q <= resp_sub_d;
      cnt_q      <= cnt_d;
`ifdef OSD_REGACCESS_STALL_EN
      stall_q    <= stall_d;
`endif
    end
  end

endmodule

// File: tb/tb_osd_reg_access.sv
// Bench for osd_reg_access: table of request packets with a response-flit scoreboard,
// a module-register responder, and hand sequences for malformed packets, backpressure and reset.
module tb_osd_reg_access;
  import osd_dii_pkg::*;

`ifdef OSD_REGACCESS_STALL_EN
  localparam bit STALL_EN = 1'b1;
`else
  localparam bit STALL_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic [9:0]  id = 10'd5;
  dii_flit     debug_in;
  logic        debug_in_ready;
  dii_flit     debug_out;
  logic        debug_out_ready;
  logic        reg_request, reg_write;
  logic [15:0] reg_addr;
  logic [1:0]  reg_size;
  logic [15:0] reg_wdata;
  logic        reg_ack, reg_err;
  logic [15:0] reg_rdata;
  logic        stall;

  osd_reg_access #(.MODID(16'h0001), .MODVERSION(16'h0000), .MAX_REG_SIZE(16)) dut (
    .clk(clk), .rst(rst), .id(id),
    .debug_in(debug_in), .debug_in_ready(debug_in_ready),
    .debug_out(debug_out), .debug_out_ready(debug_out_ready),
    .reg_request(reg_request), .reg_write(reg_write), .reg_addr(reg_addr),
    .reg_size(reg_size), .reg_wdata(reg_wdata),
    .reg_ack(reg_ack), .reg_err(reg_err), .reg_rdata(reg_rdata),
    .stall(stall)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] hdr;
    logic [15:0] addr;
    logic [15:0] wdata;
    int          delay;     // responder cycles before ack/err
    int          mode;      // 0 ack, 1 err, 2 both
    logic [15:0] rdata;
    logic [3:0]  exp_sub;
    logic [15:0] exp_data;
    bit          exp_req;
    bit          exp_stall;
  } vec_t;

  localparam int NV = 16;
  vec_t        vecs[NV];
  logic [16:0] exp_q[$];
  int          n_checks = 0, n_fail = 0;
  int          req_count = 0, rx_count = 0;
  int          cur = 0;
  logic [16:0] held;
  bit          held_valid = 1'b0;
  int          req_cycles = 0;
  bit          acked = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Response monitor: a flit is consumed at the posedge following a negedge with valid & ready.
  always @(negedge clk) begin
    if (rst) begin
      if (debug_out.valid) begin
        if (held_valid) chk("hold", {debug_out.last, debug_out.data}, held);
        if (debug_out_ready) begin
          rx_count++;
          held_valid = 1'b0;
          if (exp_q.size() == 0) begin
            n_checks++; n_fail++;
            $display("FAIL extra_flit: got %h expected none", {debug_out.last, debug_out.data});
          end else begin
            chk("flit", {debug_out.last, debug_out.data}, exp_q.pop_front());
          end
        end else begin
          held_valid = 1'b1;
          held = {debug_out.last, debug_out.data};
        end
      end else held_valid = 1'b0;
    end
  end

  // Module-register responder.
  always @(negedge clk) begin
    if (acked) begin
      chk("req_drop", reg_request, 0);
      acked = 1'b0;
    end
    reg_ack = 1'b0; reg_err = 1'b0; reg_rdata = 16'hDEAD;
    if (rst && reg_request) begin
      if (req_cycles == 0) req_count++;
      chk("reg_write", reg_write, vecs[cur].hdr[12]);
      chk("reg_addr", reg_addr, vecs[cur].addr);
      chk("reg_size", reg_size, vecs[cur].hdr[11:10]);
      if (vecs[cur].hdr[12]) chk("reg_wdata", reg_wdata, vecs[cur].wdata);
      if (req_cycles >= vecs[cur].delay) begin
        reg_ack   = (vecs[cur].mode != 1);
        reg_err   = (vecs[cur].mode != 0);
        reg_rdata = vecs[cur].rdata;
        acked = 1'b1;
        req_cycles = 0;
      end else req_cycles++;
    end
  end

  task automatic send_flit(input logic [15:0] data, input logic last);
    bit ok = 1'b0;
    debug_in = {1'b1, last, data};
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (debug_in_ready) begin ok = 1'b1; break; end
    end
    if (!ok) begin
      $display("FAIL in_ready_timeout: got 0 expected 1");
      n_checks++; n_fail++;
    end
    @(posedge clk); #1;
    debug_in = '0;
  endtask

  task automatic send_req(input logic [15:0] hdr, input logic [15:0] addr, input logic [15:0] wdata);
    int nwr;
    nwr = hdr[12] ? (1 << hdr[11:10]) : 0;
    send_flit(16'h0005, 1'b0);
    send_flit(16'h0003, 1'b0);
    send_flit(hdr, 1'b0);
    send_flit(addr, nwr == 0);
    for (int k = 0; k < nwr; k++) send_flit(wdata, k == nwr - 1);
  endtask

  task automatic push_resp(input logic [3:0] sub, input logic [15:0] data);
    exp_q.push_back({1'b0, 16'h0003});
    exp_q.push_back({1'b0, 16'h0005});
    exp_q.push_back({sub[3:2] != 2'b10, 2'b00, sub, 10'h000});
    if (sub[3:2] == 2'b10) exp_q.push_back({1'b1, data});
  endtask

  task automatic wait_idle();
    bit ok = 1'b0;
    for (int i = 0; i < 300; i++) begin
      @(posedge clk); #2;
      if (exp_q.size() == 0 && !debug_out.valid && !reg_request) begin ok = 1'b1; break; end
    end
    chk("idle_timeout", ok, 1);
    if (!ok) exp_q.delete();
  endtask

  initial begin
    int rb, xb;
    //          hdr       addr      wdata   dly mode rdata     sub    data      req  stall
    vecs[0]  = '{16'h0000, 16'h0000, 16'h0, 0, 0, 16'h0,    4'd8,  16'h0001, 0, 0};
    vecs[1]  = '{16'h0000, 16'h0001, 16'h0, 0, 0, 16'h0,    4'd8,  16'h0000, 0, 0};
    vecs[2]  = '{16'h1000, 16'h0000, 16'h5, 0, 0, 16'h0,    4'd15, 16'h0,    0, 0};
    vecs[3]  = '{16'h1000, 16'h0001, 16'h5, 0, 0, 16'h0,    4'd15, 16'h0,    0, 0};
    vecs[4]  = '{16'h0000, 16'h0003, 16'h0, 0, 0, 16'h0,    4'd12, 16'h0,    0, 0};
    vecs[5]  = '{16'h0000, 16'h01FF, 16'h0, 0, 0, 16'h0,    4'd12, 16'h0,    0, 0};
    vecs[6]  = '{16'h1000, 16'h0203, 16'h3, 2, 0, 16'h0,    4'd14, 16'h0,    1, 0};
    vecs[7]  = '{16'h0000, 16'h0300, 16'h0, 1, 1, 16'h0,    4'd12, 16'h0,    1, 0};
    vecs[8]  = '{16'h0000, 16'h0210, 16'h0, 0, 0, 16'hBEEF, 4'd8,  16'hBEEF, 1, 0};
    vecs[9]  = '{16'h0400, 16'h0200, 16'h0, 0, 0, 16'h0,    4'd12, 16'h0,    0, 0};
    vecs[10] = '{16'h1400, 16'h0200, 16'h7, 0, 0, 16'h0,    4'd15, 16'h0,    0, 0};
    vecs[11] = '{16'h0400, 16'h0000, 16'h0, 0, 0, 16'h0,    4'd12, 16'h0,    0, 0};
    vecs[12] = '{16'h0000, 16'h0220, 16'h0, 0, 2, 16'h1111, 4'd12, 16'h0,    1, 0};
    vecs[13] = '{16'h1000, 16'h0400, 16'h9, 3, 1, 16'h0,    4'd15, 16'h0,    1, 0};
    vecs[14] = '{16'h1000, 16'h0002, 16'h1, 0, 0, 16'h0,    STALL_EN ? 4'd14 : 4'd15, 16'h0, 0, STALL_EN};
    vecs[15] = '{16'h0000, 16'h0002, 16'h0, 0, 0, 16'h0,    STALL_EN ? 4'd8 : 4'd12, 16'h0001, 0, STALL_EN};

    rst = 1'b0; debug_in = '0; debug_out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #2;
    chk("rst_out_valid", debug_out.valid, 0);
    chk("rst_out_last", debug_out.last, 0);
    chk("rst_reg_request", reg_request, 0);
    chk("rst_stall", stall, 0);
    chk("rst_in_ready", debug_in_ready, 1);
    @(posedge clk); #1 rst = 1'b1;
    @(posedge clk); #1;

    for (int i = 0; i < NV; i++) begin
      cur = i; rb = req_count;
      push_resp(vecs[i].exp_sub, vecs[i].exp_data);
      send_req(vecs[i].hdr, vecs[i].addr, vecs[i].wdata);
      wait_idle();
      chk($sformatf("req_count_v%0d", i), req_count - rb, vecs[i].exp_req ? 1 : 0);
      chk($sformatf("stall_v%0d", i), stall, vecs[i].exp_stall);
    end

    // Malformed: last on src flit, bad type, missing last -> no response at all.
    xb = rx_count; rb = req_count;
    send_flit(16'h0005, 1'b0); send_flit(16'h0003, 1'b1);
    send_flit(16'h0005, 1'b0); send_flit(16'h0003, 1'b0); send_flit(16'h8000, 1'b0);
    send_flit(16'h0000, 1'b0); send_flit(16'h0000, 1'b1);
    send_flit(16'h0005, 1'b0); send_flit(16'h0003, 1'b0); send_flit(16'h0000, 1'b0);
    send_flit(16'h0000, 1'b0); send_flit(16'h1234, 1'b1);
    repeat (5) @(posedge clk); #2;
    chk("malformed_rx", rx_count - xb, 0);
    chk("malformed_valid", debug_out.valid, 0);
    chk("malformed_req", req_count - rb, 0);
    // A well-formed read straight after must still work.
    cur = 0;
    push_resp(4'd8, 16'h0001);
    send_req(16'h0000, 16'h0000, 16'h0);
    wait_idle();

    // Backpressure: one flit out, then ready low for 5 cycles.
    cur = 8; xb = rx_count;
    push_resp(4'd8, 16'hBEEF);
    debug_out_ready = 1'b0;
    send_req(vecs[8].hdr, vecs[8].addr, vecs[8].wdata);
    for (int i = 0; i < 50 && !debug_out.valid; i++) begin @(posedge clk); #1; end
    debug_out_ready = 1'b1;
    @(posedge clk); #1 debug_out_ready = 1'b0;
    repeat (5) @(posedge clk);
    #1 debug_out_ready = 1'b1;
    wait_idle();
    chk("bp_flits", rx_count - xb, 4);

    // Asynchronous reset clears stall without a clock edge.
    chk("stall_before_rst", stall, STALL_EN);
    @(negedge clk); #2 rst = 1'b0;
    #1;
    chk("stall_async_rst", stall, 0);
    chk("async_rst_valid", debug_out.valid, 0);
    @(posedge clk); #1 rst = 1'b1;
    cur = 15;
    push_resp(STALL_EN ? 4'd8 : 4'd12, 16'h0000);
    send_req(16'h0000, 16'h0002, 16'h0);
    wait_idle();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got timeout expected finish");
    $fatal(1, "global timeout");
  end

endmodule

// File: doc/osd_reg_access.md
# osd_reg_access

Register-access front end for an Open SoC Debug module. It receives register read/write request packets from the debug interconnect as 16-bit DII flits and serves the base registers itself. Module-specific registers (address ≥ 0x0200) go to the host module over a simple request/ack port. It sends a success or error response packet for every well-formed request.

## Interface
- MODID, 16'h0: value of base register 0x0000.
- MODVERSION, 16'h0: value of base register 0x0001.
- MAX_REG_SIZE, 16: widest register supported in bits (16/32/64/128); width of reg_wdata/reg_rdata.
- Ports:
  - clk  in  1  clock; all logic on rising edge.
  - rst  in  1  asynchronous, active-low reset.
  - id  in  10  this module's interconnect address.
  - debug_in  in  dii_flit  request flit {valid, last, data[15:0]}.
  - debug_in_ready  out  1  flit accepted when valid & ready.
  - debug_out  out  dii_flit  response flit.
  - debug_out_ready  in  1  flit consumed when valid & ready.
  - reg_request  out  1  module-register access pending.
  - reg_write  out  1  1 = write, 0 = read.
  - reg_addr  out  16  register address.
  - reg_size  out  2  0/1/2/3 = 16/32/64/128 bit.
  - reg_wdata  out  MAX_REG_SIZE  write data.
  - reg_ack  in  1  access completed OK.
  - reg_err  in  1  access failed.
  - reg_rdata  in  MAX_REG_SIZE  read data, valid with reg_ack.
  - stall  out  1  bit 0 of control register 0x0002.

## Operation
- Request packet, one flit per handshake:
  - flit0: dest. Ignored, because routing happens upstream.
  - flit1: src[9:0].
  - flit2: header, with type [15:14] = 2'b00 and subtype [13:10].
  - flit3: address.
  - Writes only: 2^size data flits, MSB first.
  - The final flit carries last.
- Request subtypes: 0–3 = read of size 0–3; 4–7 = write of size 0–3.
- Response subtypes: 8–11 = read success of size 0–3; 12 = read error; 14 = write success; 15 = write error.
- Response packet:
  - flit0 = request src.
  - flit1 = {6'h0, id}.
  - flit2 = {2'b00, subtype, 10'h0}.
  - Read success only: data flits, MSB first.
  - last is set on the final flit.
- Malformed packets receive no response and are drained up to and including the last flit. A packet is malformed if its type ≠ 0, its subtype is not 0–7, last arrives early, or last is missing on the expected final flit.
- Base registers (all 16-bit; any other size → error):
  - 0x0000: MODID, read-only.
  - 0x0001: MODVERSION, read-only.
  - 0x0002: control, bit 0 = stall, read/write.
  - Writes to 0x0000 or 0x0001 → write error.
  - Addresses 0x0003–0x01FF → error.
- Address ≥ 0x0200 with 2^size·16 ≤ MAX_REG_SIZE: forwarded to the module port.
- Address ≥ 0x0200 with size > MAX_REG_SIZE: error response; reg_request is never asserted.
- States: IDLE, SRC, HDR, ADDR, WDATA, ACCESS, RDEST, RSRC, RHDR, RDATA, DRAIN.

## Timing
- Reset values: debug_out.valid = 0, debug_out.last = 0, reg_request = 0, stall = 0, state = IDLE.
- debug_in_ready = 1 in IDLE, SRC, HDR, ADDR, WDATA and DRAIN; 0 otherwise.
- Base-register accesses complete internally; RDEST follows the cycle after the last request flit.
- Forwarded accesses:
  - reg_request rises the cycle after the last request flit.
  - reg_write, reg_addr, reg_size and reg_wdata are stable while reg_request is high.
  - reg_request holds until reg_ack or reg_err is sampled high, then drops the next cycle.
  - ack/err may be combinational in the first request cycle. If both are high, err wins.
  - reg_rdata is captured on the ack cycle.
- Response flits:
  - debug_out.valid stays high until debug_out_ready.
  - Flit content is held while stalled.
  - One flit per cycle when ready.
- IDLE is re-entered the cycle after the last response flit is accepted.
- A stall write takes effect the cycle after the access completes, before the response is sent.

## Configuration
- OSD_REGACCESS_STALL_EN:
  - Defined: control register 0x0002 exists and drives stall.
  - Undefined: stall is tied 0, and any access to 0x0002 returns an error response.

## Test plan
Common setup: MODID = 1, MODVERSION = 0, id = 5, MAX_REG_SIZE = 16, macro defined.
- Read base register: flits 0x0005, 0x0003, 0x0000, 0x0000(last) → response 0x0003, 0x0005, 0x2000, 0x0001(last); reg_request stays 0.
- Forwarded write: flits 0x0005, 0x0003, 0x1000, 0x0203, 0x0003(last) → reg_request with write = 1, addr = 0x0203, size = 0, wdata = 0x0003; after ack, response header 0x3800(last).
- Forwarded read error: read of 0x0300 with reg_err = 1 → response header 0x3000(last), 3 flits total.
- Oversized access: 32-bit read (header 0x0400) of 0x0200 → no reg_request; response header 0x3000.
- Stall control: write 0x0001 to 0x0002 → stall = 1 and header 0x3800; read of 0x0002 returns 0x0001; rst low → stall = 0 immediately.
- Backpressure: hold debug_out_ready = 0 for 5 cycles mid-response → flit held unchanged; no flit lost or duplicated.
